// File: rtl/sd_iosync_pkg.sv
// Shared types for the srdy/drdy transfer loop: half-FSM state encodings and
// the synchronizer depth floor.
package sd_iosync_pkg;

  localparam int unsigned SYNC_MIN = 2;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_REQ  = 2'd1,
    C_DROP = 2'd2
  } c_state_e;

  typedef enum logic [1:0] {
    P_IDLE  = 2'd0,
    P_VALID = 2'd1,
    P_ACK   = 2'd2
  } p_state_e;

endpackage

// File: rtl/sd_sync_level.sv
// N-flop level synchronizer for one handshake bit; all flops clear to 0 on
// synchronous active-low reset.
module sd_sync_level #(
  parameter int unsigned stages = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [stages-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[stages-2:0], i_d};
    end
  end

  assign o_q = r_sync[stages-1];

endmodule

// File: rtl/sd_iosync_loop.sv
// srdy/drdy to srdy/drdy transfer through a 4-phase req/ack link whose
// handshake levels are always resynchronized, so the halves can be split later.
module sd_iosync_loop
  import sd_iosync_pkg::*;
#(
  parameter int unsigned width       = 16,
  parameter int unsigned sync_stages = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c_srdy,
  output logic             c_drdy,
  input  logic [width-1:0] c_data,
  output logic             p_srdy,
  input  logic             p_drdy,
  output logic [width-1:0] p_data,
  output logic             s_req,
  output logic             s_ack
);

  localparam int unsigned STAGES = (sync_stages < SYNC_MIN) ? SYNC_MIN : sync_stages;

  c_state_e         r_c_state;
  p_state_e         r_p_state;
  logic             r_s_req;
  logic             r_s_ack;
  logic [width-1:0] r_s_data;
  logic [width-1:0] r_p_data;
  logic             r_p_srdy;
  logic             w_req_sync;
  logic             w_ack_sync;
  logic             w_c_drdy;
  logic             w_c_xfer;
  logic             w_p_xfer;

  sd_sync_level #(.stages(STAGES)) u_req_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (r_s_req),
    .o_q   (w_req_sync)
  );

  sd_sync_level #(.stages(STAGES)) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (r_s_ack),
    .o_q   (w_ack_sync)
  );

  assign w_c_drdy = (r_c_state == C_IDLE) && reset;
  assign w_c_xfer = c_srdy && w_c_drdy;
  assign w_p_xfer = r_p_srdy && p_drdy;

  // Consumer half: capture upstream word, raise req, drop it once ack is seen,
  // then wait for ack to fall before accepting the next word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_c_state <= C_IDLE;
      r_s_req   <= 1'b0;
      r_s_data  <= '0;
    end else begin
      case (r_c_state)
        C_IDLE: begin
          if (w_c_xfer) begin
            r_s_data  <= c_data;
            r_s_req   <= 1'b1;
            r_c_state <= C_REQ;
          end
        end
        C_REQ: begin
          if (w_ack_sync) begin
            r_s_req   <= 1'b0;
            r_c_state <= C_DROP;
          end
        end
        C_DROP: begin
          if (!w_ack_sync) begin
            r_c_state <= C_IDLE;
          end
        end
        default: r_c_state <= C_IDLE;
      endcase
    end
  end

  // Producer half: present the linked word downstream, ack after it is taken,
  // and release ack only once req has been seen low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_p_state <= P_IDLE;
      r_p_srdy  <= 1'b0;
      r_p_data  <= '0;
      r_s_ack   <= 1'b0;
    end else begin
      case (r_p_state)
        P_IDLE: begin
          if (w_req_sync) begin
            r_p_data  <= r_s_data;
            r_p_srdy  <= 1'b1;
            r_p_state <= P_VALID;
          end
        end
        P_VALID: begin
          if (w_p_xfer) begin
            r_p_srdy  <= 1'b0;
            r_s_ack   <= 1'b1;
            r_p_state <= P_ACK;
          end
        end
        P_ACK: begin
          if (!w_req_sync) begin
            r_s_ack   <= 1'b0;
            r_p_state <= P_IDLE;
          end
        end
        default: r_p_state <= P_IDLE;
      endcase
    end
  end

  assign c_drdy = w_c_drdy;
  assign p_srdy = r_p_srdy;
  assign p_data = r_p_data;
  assign s_req  = r_s_req;
  assign s_ack  = r_s_ack;

endmodule

// File: tb/tb_sd_iosync_loop.sv
// Directed bench for sd_iosync_loop: per-word latency vectors, streaming
// patterns with an in-order scoreboard, reset mid-transfer.
module tb_sd_iosync_loop;

  logic        clk;
  logic        reset;
  logic        c_srdy;
  logic        c_drdy;
  logic [15:0] c_data;
  logic        p_srdy;
  logic        p_drdy;
  logic [15:0] p_data;
  logic        s_req;
  logic        s_ack;

  int n_checks = 0;
  int n_fail   = 0;
  int rx_cnt   = 0;
  int seq_next = 0;
  logic [15:0] last_rx = '0;
  logic [15:0] exp_q[$];

  sd_iosync_loop #(.width(16), .sync_stages(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .c_srdy (c_srdy),
    .c_drdy (c_drdy),
    .c_data (c_data),
    .p_srdy (p_srdy),
    .p_drdy (p_drdy),
    .p_data (p_data),
    .s_req  (s_req),
    .s_ack  (s_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and hold monitor, sampled mid-cycle.
  logic        hold_prev = 1'b0;
  logic [15:0] hold_data = '0;
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
    end else begin
      if (hold_prev) chk("p_hold", {15'd0, p_srdy, p_data}, {15'd0, 1'b1, hold_data});
      if (c_srdy && c_drdy) exp_q.push_back(c_data);
      if (p_srdy && p_drdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'(p_data), 32'hFFFF_FFFF);
        end else begin
          chk("p_data_order", 32'(p_data), 32'(exp_q.pop_front()));
        end
        last_rx = p_data;
        rx_cnt++;
      end
    end
    hold_prev = reset && p_srdy && !p_drdy;
    hold_data = p_data;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle();
    int w;
    w = 0;
    while (!c_drdy && w < 60) begin
      tick();
      w++;
    end
    chk("wait_idle", 32'(c_drdy), 32'd1);
  endtask

  task automatic run_stream(input int n, input logic [7:0] sp, input logic [7:0] dp,
                            input bit chk_gap);
    int sent, got0, cyc, last_p;
    logic cx, px;
    sent = 0; got0 = rx_cnt; cyc = 0; last_p = -1;
    while ((rx_cnt - got0) < n && cyc < 5000) begin
      c_srdy = (sent < n) && sp[3'(cyc % 8)];
      c_data = 16'(seq_next);
      p_drdy = dp[3'(cyc % 8)];
      cx = c_srdy && c_drdy;
      px = p_srdy && p_drdy;
      tick();
      if (cx) begin
        sent++;
        seq_next++;
      end
      if (px) begin
        if (chk_gap && last_p >= 0) chk("full_rate_gap", 32'(cyc - last_p), 32'd14);
        last_p = cyc;
      end
      cyc++;
    end
    c_srdy = 1'b0;
    p_drdy = 1'b0;
    chk("stream_count", 32'(rx_cnt - got0), 32'(n));
  endtask

  typedef struct {
    logic [15:0] data;
    int          d;          // cycles p_drdy held low after p_srdy rises
    int          sreq_rise;  // offsets relative to the c transfer edge T
    int          psrdy_rise;
    int          sack_rise;
    int          sreq_fall;
    int          cdrdy_back;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int sreq_r, psrdy_r, sack_r, sreq_f, cdrdy_b, base;
    logic [15:0] cap;
    logic hold_bad;

    vecs[0] = '{16'hA5A5, 0,  1, 4, 5,  8,  14};
    vecs[1] = '{16'hFFFF, 3,  1, 4, 8,  11, 17};
    vecs[2] = '{16'h0000, 1,  1, 4, 6,  9,  15};
    vecs[3] = '{16'h1234, 50, 1, 4, 55, 58, 64};

    reset = 1'b0; c_srdy = 1'b0; c_data = '0; p_drdy = 1'b0;
    repeat (3) tick();
    chk("rst_c_drdy", 32'(c_drdy), 32'd0);
    chk("rst_p_srdy", 32'(p_srdy), 32'd0);
    chk("rst_s_req",  32'(s_req),  32'd0);
    chk("rst_s_ack",  32'(s_ack),  32'd0);
    chk("rst_p_data", 32'(p_data), 32'd0);
    reset = 1'b1;
    #1;
    chk("post_rst_c_drdy", 32'(c_drdy), 32'd1);

    // Single-word latency vectors with increasing downstream backpressure.
    for (int v = 0; v < 4; v++) begin
      wait_idle();
      c_srdy = 1'b1; c_data = vecs[v].data; p_drdy = 1'b0;
      tick();
      c_srdy = 1'b0;
      sreq_r = -1; psrdy_r = -1; sack_r = -1; sreq_f = -1; cdrdy_b = -1;
      cap = '0; hold_bad = 1'b0;
      for (int k = 1; k <= vecs[v].d + 20; k++) begin
        p_drdy = (k == 4 + vecs[v].d);
        if (s_req && sreq_r < 0) sreq_r = k;
        if (!s_req && sreq_r >= 0 && sreq_f < 0) sreq_f = k;
        if (p_srdy && psrdy_r < 0) begin
          psrdy_r = k;
          cap = p_data;
        end
        if (s_ack && sack_r < 0) sack_r = k;
        if (c_drdy && cdrdy_b < 0) cdrdy_b = k;
        if (k >= 4 && k <= 4 + vecs[v].d)
          if (p_data !== vecs[v].data || !p_srdy || s_ack || !s_req || c_drdy) hold_bad = 1'b1;
        tick();
      end
      p_drdy = 1'b0;
      chk("lat_s_req_rise",  32'(sreq_r),  32'(vecs[v].sreq_rise));
      chk("lat_p_srdy_rise", 32'(psrdy_r), 32'(vecs[v].psrdy_rise));
      chk("lat_p_data",      32'(cap),     32'(vecs[v].data));
      chk("lat_s_ack_rise",  32'(sack_r),  32'(vecs[v].sack_rise));
      chk("lat_s_req_fall",  32'(sreq_f),  32'(vecs[v].sreq_fall));
      chk("lat_c_drdy_back", 32'(cdrdy_b), 32'(vecs[v].cdrdy_back));
      chk("backpressure_hold", 32'(hold_bad), 32'd0);
    end

    // Full rate 0..24, then sparse source and throttled sink.
    wait_idle();
    seq_next = 0;
    run_stream(25, 8'hFF, 8'hFF, 1'b1);
    chk("full_rate_last", 32'(last_rx), 32'd24);
    wait_idle();
    run_stream(25, 8'h01, 8'hFF, 1'b0);
    wait_idle();
    run_stream(25, 8'hFF, 8'h01, 1'b0);

    // Soak: 200 words over the four pattern mixes.
    wait_idle();
    seq_next = 0;
    base = rx_cnt;
    run_stream(50, 8'hFF, 8'hFF, 1'b0);
    run_stream(50, 8'h01, 8'h01, 1'b0);
    run_stream(50, 8'hFF, 8'h01, 1'b0);
    run_stream(50, 8'h01, 8'hFF, 1'b0);
    chk("soak_count", 32'(rx_cnt - base), 32'd200);
    chk("soak_seq",   32'(seq_next), 32'd200);
    chk("soak_last",  32'(last_rx),  32'd199);

    // Reset while the link is in C_REQ: in-flight word must vanish.
    wait_idle();
    c_srdy = 1'b1; c_data = 16'hDEAD; p_drdy = 1'b0;
    tick();
    c_srdy = 1'b0;
    chk("mid_pre_s_req", 32'(s_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_c_drdy_low", 32'(c_drdy), 32'd0);
    tick();
    chk("mid_rst_s_req",  32'(s_req),  32'd0);
    chk("mid_rst_s_ack",  32'(s_ack),  32'd0);
    chk("mid_rst_p_srdy", 32'(p_srdy), 32'd0);
    chk("mid_rst_p_data", 32'(p_data), 32'd0);
    for (int i = 0; i < 2; i++) begin
      chk("mid_rst_c_drdy", 32'(c_drdy), 32'd0);
      tick();
    end
    reset = 1'b1;
    base = rx_cnt;
    wait_idle();
    c_srdy = 1'b1; c_data = 16'h0001; p_drdy = 1'b1;
    tick();
    c_srdy = 1'b0;
    repeat (40) tick();
    chk("mid_post_count", 32'(rx_cnt - base), 32'd1);
    chk("mid_post_data",  32'(last_rx), 32'h0001);
    chk("mid_post_idle",  32'(c_drdy), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_iosync_loop.md
Name: sd_iosync_loop

Overview:
Single-clock srdy/drdy-to-srdy/drdy transfer block built from two halves joined by a 4-phase req/ack link (s_req/s_ack/s_data). The consumer half accepts words from an upstream producer and drives the link. The producer half receives each word and presents it to a downstream consumer. Both halves resynchronize the opposite side's handshake through flop synchronizers, so the halves can later be split across clock domains without any protocol change.

Parameters:
width, 16, data word width in bits
sync_stages, 2, synchronizer flops on each of s_req and s_ack (minimum 2)

Ports:
clk  in  1  single clock; all state updates on the rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
c_srdy  in  1  upstream word valid
c_drdy  out  1  block can accept a word
c_data  in  width  upstream word
p_srdy  out  1  downstream word valid
p_drdy  in  1  downstream ready
p_data  out  width  downstream word
s_req  out  1  link request level, status only
s_ack  out  1  link acknowledge level, status only

Behaviour:
- Reset (reset == 0 at a clock edge):
  - Both FSMs go to IDLE.
  - s_req, s_ack, p_srdy and all synchronizer flops clear to 0.
  - s_data and p_data clear to 0.
  - c_drdy is 0 while reset is low; c_drdy = (C state == C_IDLE) AND reset.
- Transfer rules:
  - c side: a transfer occurs on an edge where c_srdy and c_drdy are both 1.
  - p side: a transfer occurs on an edge where p_srdy and p_drdy are both 1.
- C FSM:
  - C_IDLE: on a c transfer, s_data <= c_data, s_req <= 1, go to C_REQ.
  - C_REQ: when ack_sync == 1, s_req <= 0, go to C_DROP.
  - C_DROP: when ack_sync == 0, go to C_IDLE.
  - s_data changes only in C_IDLE.
- P FSM:
  - P_IDLE: when req_sync == 1, p_data <= s_data, p_srdy <= 1, go to P_VALID.
  - P_VALID: on a p transfer, p_srdy <= 0, s_ack <= 1, go to P_ACK.
  - P_ACK: when req_sync == 0, s_ack <= 0, go to P_IDLE.
- Synchronizers:
  - req_sync is s_req delayed by sync_stages flops; ack_sync is s_ack delayed by sync_stages flops.
  - The link path never bypasses these flops, even with a single clock.
- Latency (sync_stages = 2):
  - c transfer at cycle T: s_req = 1 at T+1, p_srdy = 1 at T+4.
  - p transfer at cycle A: s_ack = 1 at A+1, s_req = 0 at A+4, s_ack = 0 at A+7, c_drdy = 1 at A+10.
  - Minimum spacing between accepted words with p_drdy held at 1: 14 cycles.
- Ordering and integrity: every accepted word appears exactly once, in order, bit-exact. No loss and no duplication.
- Stability under backpressure: p_data and p_srdy hold while p_drdy = 0. s_data holds while s_req or ack_sync is 1.
- Simultaneous events: a c_srdy asserted while not in C_IDLE waits, and c_drdy stays 0. P_ACK never recaptures because it requires req_sync = 0 first.
- Reset mid-transfer: any in-flight word is discarded. The first post-reset word still arrives correctly.
- Out of scope: only 4-phase handshaking; no FIFO depth beyond the single holding register on each side.

Decomposition:
- Package sd_iosync_pkg holds:
  - C state enum {C_IDLE, C_REQ, C_DROP}
  - P state enum {P_IDLE, P_VALID, P_ACK}
  - localparam SYNC_MIN = 2
- Sub-module sd_sync_level: parameterized N-flop 1-bit synchronizer, reset to 0. Instantiate it twice, once for req and once for ack.
- The C half and P half each live in their own always block inside sd_iosync_loop.

Test Plan:
- Full-rate check: c_srdy always offered, p_drdy = 1, 25 words of incrementing data 0..24.
  - p_data sequence 0..24 exactly.
  - Consecutive p transfers 14 cycles apart.
- Single-word latency: c_data = 16'hA5A5 accepted at cycle T.
  - s_req rises at T+1, p_srdy rises at T+4 with p_data = 16'hA5A5.
  - c_drdy returns at T+14.
- Sparse and throttled traffic: srdy pattern 8'h01, then drdy pattern 8'h01 (active 1 cycle in 8), 25 words each.
  - All words arrive in order.
  - p_data stable while p_srdy = 1 and p_drdy = 0.
- Soak: 200 words mixing srdy patterns {FF, 01} with drdy patterns {FF, 01}.
  - Checker's last sequence value is 200 with no mismatch.
  - No timeout within 250000 ns at a 10 ns clock.
- Reset mid-transfer: drive reset = 0 for 3 cycles while in C_REQ.
  - All outputs are 0 on the next edge and c_drdy = 0 during reset.
  - After release, word 16'h0001 is delivered once.
- Backpressure hold: p_drdy = 0 for 50 cycles after p_srdy rises.
  - s_ack stays 0 and s_req stays 1.
  - c_drdy stays 0 until the word is consumed.
